// File: rtl/bp_resolve_queue_if.sv
// Fetch/execute handshake bundle for the branch resolve queue.
// master = predictor + branch unit side, slave = the queue.
interface bp_resolve_queue_if #(
    parameter int word_width = 32
);
    logic                  pred_valid;
    logic                  pred_taken;
    logic [word_width-1:0] pred_addr;
    logic                  pred_ready;
    logic                  res_valid;
    logic                  res_taken;
    logic [word_width-1:0] res_target;
    logic [word_width-1:0] res_fallthrough;
    logic                  res_ready;

    modport master (
        output pred_valid, pred_taken, pred_addr,
        output res_valid, res_taken, res_target, res_fallthrough,
        input  pred_ready, res_ready
    );

    modport slave (
        input  pred_valid, pred_taken, pred_addr,
        input  res_valid, res_taken, res_target, res_fallthrough,
        output pred_ready, res_ready
    );
endinterface

// File: rtl/bp_resolve_queue.sv
// In-order queue of fetch-time predictions, checked against execute outcomes;
// emits a registered mispredict/redirect pulse and flushes wrong-path entries.
module bp_resolve_queue #(
    parameter int word_width = 32,
    parameter int depth      = 4,
    parameter int cnt_width  = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    bp_resolve_queue_if.slave          bus,
    input  logic                       flush_in,
    output logic                       mispredict,
    output logic [word_width-1:0]      redirect_addr,
    output logic [$clog2(depth):0]     occupancy,
    output logic [cnt_width-1:0]       mispredict_cnt
);
    localparam int ptr_w = $clog2(depth);
    localparam logic [ptr_w:0] full_occ = (ptr_w + 1)'(depth);

    logic [ptr_w-1:0]      wr_ptr_q, wr_ptr_d;
    logic [ptr_w-1:0]      rd_ptr_q, rd_ptr_d;
    logic [ptr_w:0]        occ_q, occ_d;
    logic                  mispredict_q, mispredict_d;
    logic [word_width-1:0] redirect_q, redirect_d;
    logic [cnt_width-1:0]  cnt_q, cnt_d;

    logic                  taken_mem [depth];
    logic [word_width-1:0] addr_mem  [depth];

    logic                  push, pop, wrong, mis_fire;
    logic                  head_taken;
    logic [word_width-1:0] head_addr, correct_pc;

    assign bus.pred_ready = (occ_q != full_occ);
    assign bus.res_ready  = (occ_q != '0);

    assign push = bus.pred_valid & bus.pred_ready;
    assign pop  = bus.res_valid & bus.res_ready;

    assign head_taken = taken_mem[rd_ptr_q];
    assign head_addr  = addr_mem[rd_ptr_q];
    assign correct_pc = bus.res_taken ? bus.res_target : bus.res_fallthrough;
    assign wrong      = (head_taken != bus.res_taken) |
                        (bus.res_taken & head_taken & (head_addr != bus.res_target));
    // An external flush suppresses the pulse even for a mispredicting pop.
    assign mis_fire   = pop & wrong & ~flush_in;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        occ_d        = occ_q;
        mispredict_d = 1'b0;
        redirect_d   = redirect_q;
        cnt_d        = cnt_q;
        if (flush_in) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else if (mis_fire) begin
            // Everything younger than the mispredicted branch is wrong-path.
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            occ_d        = '0;
            mispredict_d = 1'b1;
            redirect_d   = correct_pc;
            if (!(&cnt_q)) cnt_d = cnt_q + 1'b1;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            occ_d = occ_q + {{ptr_w{1'b0}}, push} - {{ptr_w{1'b0}}, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            occ_q        <= '0;
            mispredict_q <= 1'b0;
            redirect_q   <= '0;
            cnt_q        <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            occ_q        <= occ_d;
            mispredict_q <= mispredict_d;
            redirect_q   <= redirect_d;
            cnt_q        <= cnt_d;
        end
    end

    // Entry contents need no reset; occupancy alone decides what is live.
    always_ff @(posedge clk) begin
        if (push) begin
            taken_mem[wr_ptr_q] <= bus.pred_taken;
            addr_mem[wr_ptr_q]  <= bus.pred_addr;
        end
    end

    assign mispredict     = mispredict_q;
    assign redirect_addr  = redirect_q;
    assign occupancy      = occ_q;
    assign mispredict_cnt = cnt_q;
endmodule

// File: tb/tb_bp_resolve_queue.sv
// Scoreboard bench: a reference queue model predicts occupancy/flags/counters,
// and expected redirect addresses are queued until the DUT pulses.
module tb_bp_resolve_queue;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush_in = 1'b0;
  always #5 clk = ~clk;

  bp_resolve_queue_if #(.word_width(32)) bus ();
  bp_resolve_queue_if #(.word_width(32)) bus2 ();

  logic        mispredict, mispredict2;
  logic [31:0] redirect_addr, redirect_addr2;
  logic [2:0]  occupancy, occupancy2;
  logic [15:0] mispredict_cnt;
  logic [1:0]  mispredict_cnt2;

  assign bus2.pred_valid      = bus.pred_valid;
  assign bus2.pred_taken      = bus.pred_taken;
  assign bus2.pred_addr       = bus.pred_addr;
  assign bus2.res_valid       = bus.res_valid;
  assign bus2.res_taken       = bus.res_taken;
  assign bus2.res_target      = bus.res_target;
  assign bus2.res_fallthrough = bus.res_fallthrough;

  bp_resolve_queue #(.word_width(32), .depth(4), .cnt_width(16)) dut (
    .clk(clk), .reset(rst_n), .bus(bus), .flush_in(flush_in),
    .mispredict(mispredict), .redirect_addr(redirect_addr),
    .occupancy(occupancy), .mispredict_cnt(mispredict_cnt));

  // Narrow-counter copy sees identical stimulus to exercise saturation.
  bp_resolve_queue #(.word_width(32), .depth(4), .cnt_width(2)) dut_sat (
    .clk(clk), .reset(rst_n), .bus(bus2), .flush_in(flush_in),
    .mispredict(mispredict2), .redirect_addr(redirect_addr2),
    .occupancy(occupancy2), .mispredict_cnt(mispredict_cnt2));

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // reference model state
  logic [32:0] mq[$];
  logic [31:0] sb[$];
  logic [31:0] m_redir = 32'h0;
  int          m_cnt = 0;
  int          m_cnt2 = 0;

  task automatic cycle();
    bit push, pop, wrong, pulse;
    logic [31:0] cpc;
    pulse = 1'b0;
    push  = bus.pred_valid && (mq.size() != 4);
    pop   = bus.res_valid && (mq.size() != 0);
    cpc   = bus.res_taken ? bus.res_target : bus.res_fallthrough;
    wrong = 1'b0;
    if (pop)
      wrong = (mq[0][32] != bus.res_taken) ||
              (bus.res_taken && mq[0][32] && (mq[0][31:0] != bus.res_target));
    if (!rst_n) begin
      mq.delete(); m_cnt = 0; m_cnt2 = 0; m_redir = 32'h0;
    end else if (flush_in) begin
      mq.delete();
    end else if (pop && wrong) begin
      mq.delete();
      pulse = 1'b1;
      sb.push_back(cpc);
      m_redir = cpc;
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt2 < 3) m_cnt2++;
    end else begin
      if (push) mq.push_back({bus.pred_taken, bus.pred_addr});
      if (pop) void'(mq.pop_front());
    end
    @(posedge clk);
    #1;
    chk("mispredict", mispredict, pulse);
    if (mispredict) begin
      if (sb.size() != 0) chk("redirect_pulse", redirect_addr, sb.pop_front());
      else chk("spurious_pulse", 1'b1, 1'b0);
    end else if (sb.size() != 0) begin
      chk("missing_pulse", 1'b0, 1'b1);
      void'(sb.pop_front());
    end
    chk("redirect_addr", redirect_addr, m_redir);
    chk("occupancy", occupancy, mq.size());
    chk("pred_ready", bus.pred_ready, mq.size() != 4);
    chk("res_ready", bus.res_ready, mq.size() != 0);
    chk("cnt", mispredict_cnt, m_cnt);
    chk("cnt_sat", mispredict_cnt2, m_cnt2);
    chk("occ_sat_copy", occupancy2, mq.size());
  endtask

  task automatic drv(input bit pv, input bit pt, input logic [31:0] pa,
                     input bit rv, input bit rt, input logic [31:0] rtg,
                     input logic [31:0] rft, input bit fl);
    bus.pred_valid = pv; bus.pred_taken = pt; bus.pred_addr = pa;
    bus.res_valid = rv; bus.res_taken = rt; bus.res_target = rtg;
    bus.res_fallthrough = rft; flush_in = fl;
    cycle();
  endtask

  task automatic push(input bit t, input logic [31:0] a);
    drv(1, t, a, 0, 0, 0, 0, 0);
  endtask

  task automatic res(input bit t, input logic [31:0] tg, input logic [31:0] ft);
    drv(0, 0, 0, 1, t, tg, ft, 0);
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    idle(); idle();
    rst_n = 1'b1;
    // correct prediction
    push(1, 32'h100);
    res(1, 32'h100, 32'h104);
    // target mismatch with younger entries behind it
    push(1, 32'h200); push(0, 32'h0); push(1, 32'h300);
    res(1, 32'h204, 32'h1f4);
    idle();
    // direction mispredicts both ways
    push(0, 32'h0);
    res(1, 32'h40, 32'h1c);
    idle();
    push(1, 32'h40);
    res(0, 32'h40, 32'h1c);
    idle();
    // full, dropped 5th push, wrap-around drain
    push(1, 32'h10); push(0, 32'h0); push(1, 32'h30); push(1, 32'h40);
    push(1, 32'h50);
    res(1, 32'h10, 32'h4); res(0, 32'h0, 32'h0);
    push(1, 32'h60); push(0, 32'h0);
    res(1, 32'h30, 32'h0); res(1, 32'h40, 32'h0);
    // simultaneous push+pop at occupancy 2
    drv(1, 1, 32'h70, 1, 1, 32'h60, 32'h0, 0);
    res(0, 32'h0, 32'h0); res(1, 32'h70, 32'h0);
    // resolve while empty
    res(1, 32'h80, 32'h84);
    // flush alongside a mispredicting pop
    push(1, 32'h90);
    drv(1, 0, 32'h0, 1, 0, 32'h0, 32'h94, 1);
    idle();
    // mispredict edge with a simultaneous push
    push(0, 32'h0);
    drv(1, 1, 32'ha0, 1, 1, 32'hb0, 32'h4, 0);
    idle();
    // reset mid-operation with a pulse pending
    push(1, 32'h10); push(1, 32'h20); push(1, 32'h30);
    rst_n = 1'b0;
    drv(0, 0, 0, 1, 0, 32'h0, 32'h14, 0);
    rst_n = 1'b1;
    idle();
    // random traffic over a small address set
    for (int i = 0; i < 300; i++)
      drv($urandom_range(0, 1), $urandom_range(0, 1), 32'($urandom_range(0, 3)) << 2,
          $urandom_range(0, 1), $urandom_range(0, 1), 32'($urandom_range(0, 3)) << 2,
          32'h100, ($urandom_range(0, 19) == 0));
    idle();
    chk("cnt_saturated", mispredict_cnt2, 2'd3);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
